// File: rtl/spi_master_shifter_if.sv
// Bundle of the shift engine's handshake, divider and SPI pin signals.
// The "master" modport is the shift engine's view; "slave" is the view of
// everything around it (host logic, frequency divider and SPI peripheral).
interface spi_master_shifter_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  div_clock_i;
  logic                  div_enable_o;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  sclk_o;
  logic                  mosi_o;
  logic                  miso_i;
  logic                  cs_n_o;

  modport master (
    input  div_clock_i,
    input  start_i,
    input  data_i,
    input  miso_i,
    output div_enable_o,
    output data_o,
    output busy_o,
    output done_o,
    output sclk_o,
    output mosi_o,
    output cs_n_o
  );

  modport slave (
    output div_clock_i,
    output start_i,
    output data_i,
    output miso_i,
    input  div_enable_o,
    input  data_o,
    input  busy_o,
    input  done_o,
    input  sclk_o,
    input  mosi_o,
    input  cs_n_o
  );

endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) shift engine. It gates an external
// frequency divider, detects the divided clock's edges in the system clock
// domain and runs one DATA_WIDTH-bit transfer per accepted start request.
// All outputs come straight from flops, so an async reset forces the pins
// to their idle levels immediately.
module spi_master_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  spi_master_shifter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_div_q;
  logic [DATA_WIDTH-1:0]   r_tx_sr;
  logic [DATA_WIDTH-1:0]   r_rx_sr;
  logic [COUNT_WIDTH-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_data_o;
  logic                    r_div_enable;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_sclk;
  logic                    r_mosi;
  logic                    r_cs_n;

  logic                    w_rise;
  logic                    w_fall;
  logic                    w_last_bit;

  // Edges of the divided clock relative to its one-cycle-delayed copy.
  // Rise and fall can never be true together since they need opposite div_q.
  assign w_rise     = bus.div_clock_i & ~r_div_q;
  assign w_fall     = ~bus.div_clock_i & r_div_q;
  assign w_last_bit = (r_bit_cnt == COUNT_WIDTH'(DATA_WIDTH));

  assign bus.div_enable_o = r_div_enable;
  assign bus.data_o       = r_data_o;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.sclk_o       = r_sclk;
  assign bus.mosi_o       = r_mosi;
  assign bus.cs_n_o       = r_cs_n;

  // Transfer FSM: edge-detect register, shift registers, counter and all pin outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_IDLE;
      r_div_q      <= 1'b0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_bit_cnt    <= '0;
      r_data_o     <= '0;
      r_div_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_cs_n       <= 1'b1;
    end else begin
      r_div_q <= bus.div_clock_i;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // sclk mirrors div_q only while shifting; div_q next cycle is
          // today's div_clock_i, which is low because the divider is idle.
          if (bus.start_i) begin
            r_tx_sr      <= bus.data_i;
            r_mosi       <= bus.data_i[DATA_WIDTH-1];
            r_rx_sr      <= '0;
            r_bit_cnt    <= '0;
            r_cs_n       <= 1'b0;
            r_div_enable <= 1'b1;
            r_busy       <= 1'b1;
            r_sclk       <= bus.div_clock_i;
            r_state      <= ST_SHIFT;
          end else begin
            r_sclk <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_sclk <= bus.div_clock_i;
          if (w_rise) begin
            r_rx_sr   <= {r_rx_sr[DATA_WIDTH-2:0], bus.miso_i};
            r_bit_cnt <= r_bit_cnt + COUNT_WIDTH'(1);
          end else if (w_fall) begin
            if (w_last_bit) begin
              r_div_enable <= 1'b0;
              r_data_o     <= r_rx_sr;
              r_sclk       <= 1'b0;
              r_state      <= ST_FINISH;
            end else begin
              // Rotate rather than zero-fill: bits past the MSB end are
              // never driven out, and rotating keeps every bit in use.
              r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], r_tx_sr[DATA_WIDTH-1]};
              r_mosi  <= r_tx_sr[DATA_WIDTH-2];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt;
          end
        end
        ST_FINISH: begin
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_mosi  <= 1'b0;
          r_sclk  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_div_enable <= 1'b0;
          r_cs_n       <= 1'b1;
          r_busy       <= 1'b0;
          r_sclk       <= 1'b0;
          r_mosi       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: behavioural frequency divider,
// selectable MISO source (loopback / tied 1 / tied 0) and a monitor that
// records sclk edges, MOSI bits at each sclk rise and done pulses.
module tb_spi_master_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_r = 1'b0;
  logic [7:0] data_r = 8'h00;
  logic       div_clk = 1'b0;
  int         div_cnt = 0;
  int         half = 5;
  int         miso_mode = 0;

  int errors = 0;
  int checks = 0;

  spi_master_shifter_if #(.DATA_WIDTH(8)) bus_if ();

  assign bus_if.div_clock_i = div_clk;
  assign bus_if.start_i     = start_r;
  assign bus_if.data_i      = data_r;
  assign bus_if.miso_i      = (miso_mode == 0) ? bus_if.mosi_o : (miso_mode == 1);

  spi_master_shifter #(.DATA_WIDTH(8), .COUNT_WIDTH(6)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if.master)
  );

  // System clock, 10 time units per period.
  always #5 clk = ~clk;

  // Divider model: restarts low from zero whenever enable is low; toggles every `half` cycles.
  always @(posedge clk) begin
    if (!bus_if.div_enable_o) begin
      div_cnt <= 0;
      div_clk <= 1'b0;
    end else if (div_cnt == half - 1) begin
      div_cnt <= 0;
      div_clk <= ~div_clk;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  int   cyc = 0;
  int   last_rise = 0;
  bit   first_r = 1'b1;
  logic prev_sclk = 1'b0;
  int   rise_total = 0;
  int   done_total = 0;
  int   phase_bad = 0;
  int   cs_bad = 0;
  int   busy_bad = 0;
  logic mosi_q[$];

  // Monitor at the falling edge: sclk phase widths, MOSI at sclk rise, CS and done behaviour.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= bus_if.sclk_o;
    if (bus_if.cs_n_o) first_r <= 1'b1;
    if (bus_if.busy_o && bus_if.cs_n_o) cs_bad <= cs_bad + 1;
    if (bus_if.sclk_o && !prev_sclk) begin
      rise_total <= rise_total + 1;
      mosi_q.push_back(bus_if.mosi_o);
      if (!first_r && (cyc - last_rise != 2 * half)) phase_bad <= phase_bad + 1;
      first_r   <= 1'b0;
      last_rise <= cyc;
    end
    if (!bus_if.sclk_o && prev_sclk && (cyc - last_rise != half)) phase_bad <= phase_bad + 1;
    if (bus_if.done_o) begin
      done_total <= done_total + 1;
      if (bus_if.busy_o) busy_bad <= busy_bad + 1;
    end
  end

  // Overall time limit so the run always ends.
  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word a SPI slave would return: loopback echoes the sent word, tied pins give all ones / zeros.
  function automatic logic [7:0] exp_rx(input int mode, input logic [7:0] d);
    case (mode)
      0:       return d;
      1:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Eight MOSI samples starting at queue position b, first sample is the MSB.
  function automatic logic [7:0] mosi_word(input int b);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b + i < mosi_q.size()) w[7-i] = mosi_q[b+i];
      else w[7-i] = 1'bx;
    end
    return w;
  endfunction

  task automatic wait_done(output bit got, output logic last_busy);
    got = 1'b0;
    last_busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus_if.done_o) begin
        got = 1'b1;
        break;
      end
      last_busy = bus_if.busy_o;
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, input int mode, input int hp, input bit mid_start);
    int b_r, b_q, b_d, b_p, b_c, b_b;
    bit got;
    logic lb;
    half = hp;
    miso_mode = mode;
    @(negedge clk);
    b_r = rise_total; b_q = mosi_q.size(); b_d = done_total;
    b_p = phase_bad;  b_c = cs_bad;        b_b = busy_bad;
    start_r = 1'b1;
    data_r  = d;
    @(negedge clk);
    start_r = 1'b0;
    data_r  = 8'($urandom);
    check("accept_cs_n", bus_if.cs_n_o, 1'b0);
    check("accept_busy", bus_if.busy_o, 1'b1);
    if (mid_start) begin
      for (int i = 0; i < 2000 && (rise_total - b_r) < 2; i++) @(negedge clk);
      start_r = 1'b1;
      data_r  = 8'h3C;
      @(negedge clk);
      start_r = 1'b0;
    end
    wait_done(got, lb);
    check("done_seen", got, 1'b1);
    check("busy_before_done", lb, 1'b1);
    check("busy_at_done", bus_if.busy_o, 1'b0);
    check("cs_n_at_done", bus_if.cs_n_o, 1'b1);
    check("sclk_ends_low", bus_if.sclk_o, 1'b0);
    check("data_o", bus_if.data_o, exp_rx(mode, d));
    @(negedge clk);
    check("done_one_cycle", bus_if.done_o, 1'b0);
    check("sclk_rises", rise_total - b_r, 8);
    check("mosi_bits", mosi_word(b_q), d);
    check("sclk_phases", phase_bad - b_p, 0);
    check("cs_low_while_busy", cs_bad - b_c, 0);
    check("busy_clear_at_done", busy_bad - b_b, 0);
    check("done_count", done_total - b_d, 1);
  endtask

  initial begin
    int b_r, b_q, b_d;
    bit got;
    logic lb;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus_if.cs_n_o, 1'b1);
    check("rst_div_en", bus_if.div_enable_o, 1'b0);
    check("rst_sclk", bus_if.sclk_o, 1'b0);
    check("rst_mosi", bus_if.mosi_o, 1'b0);
    check("rst_busy", bus_if.busy_o, 1'b0);
    check("rst_done", bus_if.done_o, 1'b0);
    check("rst_data_o", bus_if.data_o, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5 at 100MHz/10MHz
    do_xfer(8'hA5, 0, 5, 1'b0);
    // MISO tied high / low with all-zero transmit word
    do_xfer(8'h00, 1, 5, 1'b0);
    do_xfer(8'h00, 2, 5, 1'b0);
    // Start pulsed mid-transfer is ignored
    do_xfer(8'hC6, 0, 5, 1'b1);
    repeat (4) @(negedge clk);
    check("no_queued_start", bus_if.cs_n_o, 1'b1);

    // Back-to-back: start held from FINISH through the done cycle
    half = 5;
    miso_mode = 0;
    @(negedge clk);
    b_r = rise_total; b_q = mosi_q.size(); b_d = done_total;
    start_r = 1'b1;
    data_r  = 8'hA5;
    @(negedge clk);
    start_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((rise_total - b_r) >= 8 && !bus_if.sclk_o && bus_if.busy_o) break;
      @(negedge clk);
    end
    start_r = 1'b1;
    data_r  = 8'h81;
    @(negedge clk);
    check("b2b_done_cycle", bus_if.done_o, 1'b1);
    check("b2b_not_taken_in_finish", bus_if.cs_n_o, 1'b1);
    check("b2b_first_data", bus_if.data_o, 8'hA5);
    @(negedge clk);
    start_r = 1'b0;
    check("b2b_accept_cs_n", bus_if.cs_n_o, 1'b0);
    check("b2b_accept_busy", bus_if.busy_o, 1'b1);
    wait_done(got, lb);
    check("b2b_done_seen", got, 1'b1);
    check("b2b_data_o", bus_if.data_o, 8'h81);
    repeat (4) @(negedge clk);
    check("b2b_done_count", done_total - b_d, 2);
    check("b2b_rises", rise_total - b_r, 16);
    check("b2b_mosi_second", mosi_word(b_q + 8), 8'h81);
    check("b2b_idle_after", bus_if.cs_n_o, 1'b1);

    // Half-period sweep
    do_xfer(8'h5A, 0, 2, 1'b0);
    do_xfer(8'h5A, 0, 5, 1'b0);
    do_xfer(8'h5A, 0, 50, 1'b0);

    // Abort by reset after the third sclk rise
    half = 5;
    miso_mode = 0;
    @(negedge clk);
    b_r = rise_total; b_d = done_total;
    start_r = 1'b1;
    data_r  = 8'hE7;
    @(negedge clk);
    start_r = 1'b0;
    for (int i = 0; i < 2000 && (rise_total - b_r) < 3; i++) @(negedge clk);
    check("abort_mid_transfer", bus_if.cs_n_o, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs_n", bus_if.cs_n_o, 1'b1);
    check("abort_div_en", bus_if.div_enable_o, 1'b0);
    check("abort_sclk", bus_if.sclk_o, 1'b0);
    check("abort_busy", bus_if.busy_o, 1'b0);
    check("abort_data_o", bus_if.data_o, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_total - b_d, 0);
    check("abort_data_held", bus_if.data_o, 8'h00);
    do_xfer(8'h3C, 0, 5, 1'b0);

    // Random words, MISO sources and divider ratios
    for (int k = 0; k < 5; k++) begin
      do_xfer(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(2, 7)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
